// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: side encoding, read-return tag
// and default bus widths.
package dmem_arbiter_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  localparam logic SIDE_P = 1'b0;
  localparam logic SIDE_D = 1'b1;

  typedef struct packed {
    logic valid;
    logic side;
  } rd_tag_t;
endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// Latency-matched shift register of read tags; the output stage lines up with
// the syncram's mem_q for the read that pushed it.
module dmem_rd_tag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clock,
  input  logic    clear,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);
  rd_tag_t stage [RD_LAT];

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[RD_LAT-1];
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port dmem syncram between the processor
// (P) and debug/loader (D) ports, with a bounded burst lock and tagged read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_wren,
  input  logic              p_lock,
  input  logic [ADDR_W-1:0] p_address,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              d_req,
  input  logic              d_wren,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_data,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic          prio_r, owner_r, lock_r;
  logic [HW-1:0] hold_cnt;

  logic    any_req, win, win_wren, win_lock, other_req, keep_owner, gnt_ok;
  rd_tag_t tag_in, tag_out;

  always_comb begin
    any_req    = p_req | d_req;
    // Owner dropping lock this very cycle counts as unlocked.
    keep_owner = lock_r & (owner_r ? d_lock : p_lock) & (hold_cnt < HW'(MAX_HOLD));
    if (p_req & d_req) win = keep_owner ? owner_r : prio_r;
    else               win = d_req;
    win_wren   = win ? d_wren : p_wren;
    win_lock   = win ? d_lock : p_lock;
    other_req  = win ? p_req  : d_req;
    gnt_ok     = any_req & ~reset;

    p_gnt       = gnt_ok & (win == SIDE_P);
    d_gnt       = gnt_ok & (win == SIDE_D);
    mem_address = win ? d_address : p_address;
    mem_data    = win ? d_data    : p_data;
    mem_wren    = gnt_ok & win_wren;

    tag_in       = '0;
    tag_in.valid = gnt_ok & ~win_wren;
    tag_in.side  = win;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio_r   <= SIDE_P;
      owner_r  <= SIDE_P;
      lock_r   <= 1'b0;
      hold_cnt <= '0;
    end else if (any_req) begin
      prio_r  <= ~win;
      owner_r <= win;
      lock_r  <= win_lock;
      if (win == owner_r && win_lock && other_req)
        hold_cnt <= (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + HW'(1);
      else
        hold_cnt <= '0;
    end else begin
      hold_cnt <= '0;
    end
  end

  dmem_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clock   (clock),
    .clear   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Both sides see the raw syncram data; only rvalid is steered.
  assign p_rvalid = tag_out.valid & (tag_out.side == SIDE_P) & ~reset;
  assign d_rvalid = tag_out.valid & (tag_out.side == SIDE_D) & ~reset;
  assign p_rdata  = mem_q;
  assign d_rdata  = mem_q;
endmodule
